// File: rtl/mem_stage_pkg.sv
// Shared codes for the MEM stage: memory op types, load/store width codes, and
// the helper that maps a width code to the index of its final byte.
package mem_stage_pkg;
  localparam logic [1:0]  MEM_NONE  = 2'd0;
  localparam logic [1:0]  MEM_LOAD  = 2'd1;
  localparam logic [1:0]  MEM_STORE = 2'd2;

  localparam logic [2:0]  F3_LB  = 3'b000;
  localparam logic [2:0]  F3_LH  = 3'b001;
  localparam logic [2:0]  F3_LW  = 3'b010;
  localparam logic [2:0]  F3_LBU = 3'b100;
  localparam logic [2:0]  F3_LHU = 3'b101;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  typedef enum logic {ST_IDLE, ST_ACCESS} state_e;

  // Index of the last byte of an access; width codes 011/110/111 fall back to a word.
  function automatic logic [1:0] last_idx(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   last_idx = 2'd0;
      2'b01:   last_idx = 2'd1;
      default: last_idx = 2'd3;
    endcase
  endfunction
endpackage

// File: rtl/mem_stage_load_extend.sv
// Sign/zero extension of an assembled load word according to the load width code.
module load_extend
  import mem_stage_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_raw,
  output logic [31:0] o_data
);
  always_comb begin
    o_data = i_raw;
    case (i_funct3)
      F3_LB:   o_data = {{24{i_raw[7]}},  i_raw[7:0]};
      F3_LH:   o_data = {{16{i_raw[15]}}, i_raw[15:0]};
      F3_LBU:  o_data = {24'h0, i_raw[7:0]};
      F3_LHU:  o_data = {16'h0, i_raw[15:0]};
      default: o_data = i_raw;
    endcase
  end
endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-serial load/store sequencer feeding the registered
// MEM/WB write-back triple; non-memory ops pass straight through in one cycle.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  input  logic [1:0]         in_mem_type,
  input  logic [2:0]         in_funct3,
  input  logic               in_wreg,
  input  logic [RADDR_W-1:0] in_wd,
  input  logic [DATA_W-1:0]  in_wdata,
  input  logic [ADDR_W-1:0]  in_addr,
  input  logic [DATA_W-1:0]  in_sdata,
  output logic               stall_req,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [7:0]         mem_wdata,
  input  logic [7:0]         mem_rdata,
  input  logic               mem_ready,
  output logic               w_req,
  output logic [RADDR_W-1:0] w_addr,
  output logic [DATA_W-1:0]  w_data
);
  state_e            r_state, w_state_nxt;
  logic [1:0]        r_cnt;
  logic [DATA_W-1:0] r_acc;
  logic              w_is_load, w_is_store, w_is_mem, w_last;
  logic [DATA_W-1:0] w_raw;
  logic [31:0]       w_ext;

  // Reset gates the request so nothing reaches the memory port while rst is held.
  assign w_is_load  = in_valid & (in_mem_type == MEM_LOAD);
  assign w_is_store = in_valid & (in_mem_type == MEM_STORE);
  assign w_is_mem   = (w_is_load | w_is_store) & ~rst;
  assign w_last     = mem_ready & (r_cnt == last_idx(in_funct3));

  assign mem_req   = w_is_mem;
  assign mem_we    = w_is_store;
  assign mem_addr  = in_addr + ADDR_W'(r_cnt);
  assign mem_wdata = in_sdata[8*r_cnt +: 8];
  assign stall_req = w_is_mem & ~w_last;

  always_comb begin
    w_raw = r_acc;
    w_raw[8*r_cnt +: 8] = mem_rdata;
  end

  load_extend u_ext (
    .i_funct3 (in_funct3),
    .i_raw    (w_raw[31:0]),
    .o_data   (w_ext)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (w_is_mem & ~w_last)  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (~w_is_mem | w_last)  w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_is_mem && mem_ready) begin
        if (w_last) begin
          r_cnt <= 2'd0;
        end else begin
          r_cnt <= r_cnt + 2'd1;
          if (w_is_load) r_acc[8*r_cnt +: 8] <= mem_rdata;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_req  <= 1'b0;
      w_addr <= '0;
      w_data <= '0;
    end else if (w_is_mem) begin
      w_req <= 1'b0;
      if (w_last) begin
        w_req  <= w_is_load & in_wreg;
        w_addr <= in_wd;
        w_data <= DATA_W'(w_ext);
      end
    end else if (in_valid) begin
      w_req  <= in_wreg;
      w_addr <= in_wd;
      w_data <= in_wdata;
    end else begin
      w_req <= 1'b0;
    end
  end
endmodule
